gate_result_packer: RTL and testbench
=====================================

Name: gate_result_packer

Overview:
- Downstream consumer of the registered 2-bit gate-result stage.
- Collects successive 2-bit results into a packed SLOTS-wide word and presents it on a valid/ready output handshake.
- Supports a flush that emits a partially filled word.
- Keeps a running count of delivered words for monitoring and debug.

Parameters:
- SLOTS, 4, number of 2-bit results per packed word (2..8).
- CNT_W, 8, width of the delivered-word counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a result to accept.
- in_data  input  2  2-bit gate result from the upstream stage.
- in_ready  output  1  packer can accept a beat this cycle.
- flush  input  1  request emission of a partial word.
- out_valid  output  1  out_data/out_fill hold a packed word.
- out_data  output  2*SLOTS  packed word; slot 0 in bits [1:0], slot k in bits [2k+1:2k].
- out_fill  output  4  number of valid slots in out_data (1..SLOTS).
- out_ready  input  1  downstream accepts the word this cycle.
- word_count  output  CNT_W  number of words delivered since reset, modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=FILL; fill=0; accumulator=0.
  - out_valid=0, out_data=0, out_fill=0, word_count=0.
  - in_ready=1 from the first cycle after reset.
  - Reset overrides every other input, including mid-word and during HOLD; partial data is discarded.
- Accept: a beat is accepted when in_valid && in_ready.
- in_ready is combinational: 1 in FILL, 0 in HOLD.
- FILL state:
  - Each accepted beat is written into slot[fill], and fill increments.
  - When the accepted beat makes fill==SLOTS:
    - Next cycle: state=HOLD, out_valid=1, out_data=accumulator including that beat, out_fill=SLOTS.
    - fill and accumulator clear.
  - When flush=1 and (fill>0 or a beat is accepted this cycle):
    - The beat, if any, is included.
    - Next cycle: state=HOLD, out_valid=1, out_fill=the resulting fill count.
    - Unused upper slots are 0.
  - flush with fill==0 and no accepted beat is ignored.
  - flush coinciding with the beat that fills the word gives a normal full word (out_fill=SLOTS).
- HOLD state:
  - out_valid=1; out_data and out_fill are held stable until out_ready=1.
  - in_ready=0; in_valid and flush are ignored.
  - On out_valid && out_ready:
    - word_count increments, wrapping from 2^CNT_W-1 to 0.
    - Next cycle: state=FILL, out_valid=0, out_data=0, out_fill=0.
- Latency: out_valid rises exactly 1 cycle after the completing (or flushing) accept edge.
- Throughput: at most one word per SLOTS+1 cycles; no overlap between HOLD and FILL.
- out_ready while out_valid=0 has no effect.
- Outputs are registered except in_ready.
- No data loss: every accepted beat appears in exactly one delivered word.

Test Plan:
- Reset, then feed 01,10,11,00 on consecutive cycles with out_ready=1 -> next cycle out_valid=1, out_data=8'h39, out_fill=4; word_count=1 after the handshake; in_ready=0 for exactly 1 cycle.
- Complete a word (11,11,11,11) with out_ready=0 for 5 cycles -> out_data=8'hFF held stable, in_ready=0 and in_valid ignored throughout; on out_ready=1, word_count increments once and FILL resumes.
- Feed 10,01, then flush with in_valid=0 -> out_data=8'h06, out_fill=2; flush with fill=0 and in_valid=0 -> no output.
- Flush asserted together with the 3rd beat 11 after 01,01 -> out_data=8'h35, out_fill=3; flush together with the 4th beat -> out_fill=4.
- Assert rst after 2 accepted beats, and separately during HOLD -> all outputs 0, in_ready=1 next cycle, word_count=0; the next 4 beats form a clean word.
- Deliver 256 words with CNT_W=8 -> word_count wraps from 8'hFF to 8'h00; random valid/ready/flush run with a scoreboard -> order of beats and out_fill match the model, and nothing is dropped.

Source files
------------

// File: rtl/gate_result_packer_if.sv
// Packer handshake bundle: upstream beat input, flush, packed-word output, delivered-word counter.
// Pure wiring; no latency of its own.
// Backpressure travels on in_ready (packer to source) and out_ready (sink to packer).
interface gate_result_packer_if #(
    parameter int SLOTS = 4,
    parameter int CNT_W = 8
);
    logic                 in_valid;
    logic [1:0]           in_data;
    logic                 in_ready;
    logic                 flush;
    logic                 out_valid;
    logic [2*SLOTS-1:0]   out_data;
    logic [3:0]           out_fill;
    logic                 out_ready;
    logic [CNT_W-1:0]     word_count;

    // Source/sink side: drives beats, flush and out_ready; observes the packed word.
    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_fill, word_count
    );

    // Packer side.
    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_fill, word_count
    );
endinterface

// File: rtl/gate_result_packer.sv
// Packs successive 2-bit gate results into a SLOTS-wide word; flush emits a partial word.
// Latency: out_valid rises 1 cycle after the completing or flushing accept edge.
// Backpressure: while a word waits for out_ready, in_ready is low and inputs/flush are ignored.
module gate_result_packer #(
    parameter int SLOTS = 4,   // 2..8 results per word
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    gate_result_packer_if.slave bus
);
    localparam int DW = 2 * SLOTS;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             r_state;
    logic [3:0]         r_fill;
    logic [DW-1:0]      r_acc;
    logic               r_out_valid;
    logic [DW-1:0]      r_out_data;
    logic [3:0]         r_out_fill;
    logic [CNT_W-1:0]   r_word_count;

    logic               w_accept;
    logic [DW-1:0]      w_acc_next;
    logic [3:0]         w_fill_next;
    logic               w_full;
    logic               w_emit;

    // Only in_ready is combinational; it simply mirrors the state.
    assign bus.in_ready   = (r_state == ST_FILL);
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_fill   = r_out_fill;
    assign bus.word_count = r_word_count;

    assign w_accept    = bus.in_valid && (r_state == ST_FILL);
    assign w_fill_next = r_fill + {3'd0, w_accept};
    assign w_full      = w_accept && (w_fill_next == 4'(SLOTS));
    // Flush only emits when the word would carry at least one result,
    // so a flush on an empty accumulator is silently dropped.
    assign w_emit      = w_full || (bus.flush && (w_fill_next != 4'd0));

    // Accumulator view including this cycle's beat, written into the next free slot.
    // Unwritten slots stay 0 because the accumulator is cleared on every emission.
    always_comb begin
        w_acc_next = r_acc;
        for (int k = 0; k < SLOTS; k++) begin
            if (w_accept && (r_fill == 4'(k))) begin
                w_acc_next[2*k +: 2] = bus.in_data;
            end
        end
    end

    // FILL/HOLD controller with registered word outputs and delivered-word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FILL;
            r_fill       <= '0;
            r_acc        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_fill   <= '0;
            r_word_count <= '0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_emit) begin
                        r_state     <= ST_HOLD;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_acc_next;
                        r_out_fill  <= w_fill_next;
                        r_acc       <= '0;
                        r_fill      <= '0;
                    end else begin
                        r_acc  <= w_acc_next;
                        r_fill <= w_fill_next;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        r_state      <= ST_FILL;
                        r_out_valid  <= 1'b0;
                        r_out_data   <= '0;
                        r_out_fill   <= '0;
                        r_word_count <= r_word_count + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_result_packer.sv
// Self-checking bench for gate_result_packer: directed scenarios followed by a random run,
// every cycle compared against a queue-based reference model plus a beat-order scoreboard.
module tb_gate_result_packer;
    localparam int SLOTS = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gate_result_packer_if #(.SLOTS(SLOTS), .CNT_W(CNT_W)) bus();

    gate_result_packer #(.SLOTS(SLOTS), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model state
    bit  m_hold;
    int  m_beats[$];
    int  m_word;
    int  m_fill;
    int  m_count;
    int  sb[$];

    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, then compare all outputs after the edge.
    task automatic cyc(input logic v, input logic [1:0] d, input logic f,
                       input logic r, input logic rs);
        int e;
        rst           = rs;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.flush     = f;
        bus.out_ready = r;
        // Delivered word: each valid slot must be the next beat accepted, in order.
        if (!rs && m_hold && r) begin
            for (int k = 0; k < m_fill; k++) begin
                e = (sb.size() > 0) ? sb.pop_front() : -1;
                chk("sb_beat", 32'(bus.out_data[2*k +: 2]), e);
            end
        end
        if (rs) begin
            m_hold = 0; m_beats.delete(); m_word = 0; m_fill = 0; m_count = 0; sb.delete();
        end else if (!m_hold) begin
            if (v) begin
                m_beats.push_back(int'(d));
                sb.push_back(int'(d));
            end
            if (m_beats.size() == SLOTS || (f && m_beats.size() > 0)) begin
                m_hold = 1;
                m_fill = m_beats.size();
                m_word = 0;
                foreach (m_beats[i]) m_word += m_beats[i] * (4 ** i);
                m_beats.delete();
            end
        end else if (r) begin
            m_count = (m_count + 1) % (1 << CNT_W);
            m_hold = 0; m_word = 0; m_fill = 0;
        end
        @(posedge clk);
        #1;
        chk("out_valid",  bus.out_valid,  m_hold);
        chk("out_data",   bus.out_data,   m_word);
        chk("out_fill",   bus.out_fill,   m_fill);
        chk("word_count", bus.word_count, m_count);
        chk("in_ready",   bus.in_ready,   !m_hold);
    endtask

    initial begin
        // Reset
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_word_count", bus.word_count, 0);

        // Full word 01,10,11,00 with sink always ready
        cyc(1, 2'b01, 0, 1, 0);
        cyc(1, 2'b10, 0, 1, 0);
        cyc(1, 2'b11, 0, 1, 0);
        cyc(1, 2'b00, 0, 1, 0);
        chk("t1_data", bus.out_data, 32'h39);
        chk("t1_fill", bus.out_fill, 4);
        chk("t1_in_ready_low", bus.in_ready, 0);
        cyc(0, 0, 0, 1, 0);
        chk("t1_in_ready_back", bus.in_ready, 1);
        chk("t1_count", bus.word_count, 1);

        // Held word under backpressure; inputs and flush ignored while holding
        repeat (4) cyc(1, 2'b11, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 2'($urandom), 1, 0, 0);
            chk("t2_hold_data", bus.out_data, 32'hFF);
            chk("t2_hold_rdy", bus.in_ready, 0);
        end
        cyc(0, 0, 0, 1, 0);
        chk("t2_count", bus.word_count, 2);

        // Partial flush, then empty flush
        cyc(1, 2'b10, 0, 1, 0);
        cyc(1, 2'b01, 0, 1, 0);
        cyc(0, 0, 1, 0, 0);
        chk("t3_data", bus.out_data, 32'h06);
        chk("t3_fill", bus.out_fill, 2);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        chk("t3_empty_flush", bus.out_valid, 0);

        // Flush coinciding with a beat: 3rd beat, then the word-completing 4th beat
        cyc(1, 2'b01, 0, 1, 0);
        cyc(1, 2'b01, 0, 1, 0);
        cyc(1, 2'b11, 1, 0, 0);
        chk("t4_data", bus.out_data, 32'h35);
        chk("t4_fill3", bus.out_fill, 3);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 2'b00, 0, 1, 0);
        cyc(1, 2'b00, 0, 1, 0);
        cyc(1, 2'b00, 0, 1, 0);
        cyc(1, 2'b10, 1, 0, 0);
        chk("t4_fill4", bus.out_fill, 4);
        cyc(0, 0, 0, 1, 0);

        // Reset during HOLD, then reset mid-word, then a clean word
        repeat (4) cyc(1, 2'b01, 0, 0, 0);
        cyc(0, 0, 0, 1, 1);
        chk("t5_hold_rst_valid", bus.out_valid, 0);
        chk("t5_hold_rst_count", bus.word_count, 0);
        chk("t5_hold_rst_rdy", bus.in_ready, 1);
        cyc(1, 2'b11, 0, 0, 0);
        cyc(1, 2'b11, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("t5_mid_rst_data", bus.out_data, 0);
        cyc(1, 2'b11, 0, 0, 0);
        cyc(1, 2'b10, 0, 0, 0);
        cyc(1, 2'b01, 0, 0, 0);
        cyc(1, 2'b00, 0, 0, 0);
        chk("t5_clean_data", bus.out_data, 32'h1B);
        chk("t5_clean_fill", bus.out_fill, 4);
        cyc(0, 0, 0, 1, 0);

        // Counter wrap over 256 words
        cyc(0, 0, 0, 0, 1);
        for (int w = 0; w < 256; w++) begin
            repeat (4) cyc(1, 2'($urandom), 0, 1, 0);
            cyc(0, 0, 0, 1, 0);
            if (w == 254) chk("wrap_ff", bus.word_count, 32'hFF);
        end
        chk("wrap_00", bus.word_count, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 7) == 0,
                $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
        end
        // Drain: release any held word, flush the partial, deliver it
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("no_loss", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
